sc_spi_arb: RTL and testbench

SPI engine arbiter and transfer sequencer. Shares one SPI protocol engine between NREQ requesters. Each requester supplies its own SPI wave configuration and a stream of 32-bit words. The block grants the engine round-robin, holds the grant across multi-word chip-select-extended transactions, drives the engine's register-side start/config/data inputs, and returns each received word to the owning requester.

---
 rtl/sc_spi_arb.sv | 233 +++++++++++++++++++++++
 tb/tb_sc_spi_arb.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_spi_arb.sv
// -----------------------------------------------------------------------------
// sc_spi_arb
//
// Shares one SPI protocol engine between NREQ requesters.
//
// Each requester supplies its own SPI wave configuration and a stream of
// 32-bit words. The engine is granted round-robin. The grant is held across
// multi-word transactions, where chip select stays asserted between words.
// Every received word is returned to the requester that owns the transaction.
//
// Ports
//   SYSCLK, SYSRSTB        : clock, asynchronous active-low reset
//   REQ_VALID/READY/LAST   : per-requester word handshake, bit i = requester i
//   REQ_DATA, REQ_CFG      : per-requester 32-bit lanes, lane i = [32i+31:32i]
//   RSP_VALID, RSP_DATA    : one-cycle RX word pulse to the owner, shared data
//   GNT                    : one-hot current owner (0 when idle), for CS routing
//   CLKDR..BORDER          : registered SPI wave config to the engine
//   TXSTART, CSEXTEND      : engine start pulse and keep-CS-asserted flag
//   TXDATA                 : word to the engine
//   SPIBUSY, SPICOMPLETE   : engine status; RXDATA is valid with SPICOMPLETE
//   RXDATA                 : received word from the engine
// -----------------------------------------------------------------------------
module sc_spi_arb #(
  parameter int NREQ = 2
) (
  input  logic                SYSCLK,
  input  logic                SYSRSTB,
  input  logic [NREQ-1:0]     REQ_VALID,
  output logic [NREQ-1:0]     REQ_READY,
  input  logic [NREQ-1:0]     REQ_LAST,
  input  logic [NREQ*32-1:0]  REQ_DATA,
  input  logic [NREQ*32-1:0]  REQ_CFG,
  output logic [NREQ-1:0]     RSP_VALID,
  output logic [31:0]         RSP_DATA,
  output logic [NREQ-1:0]     GNT,
  output logic [7:0]          CLKDR,
  output logic [3:0]          CSSETUP,
  output logic [3:0]          CSHOLD,
  output logic [8:0]          DWIDTH,
  output logic                CPOL,
  output logic                CPHA,
  output logic                BORDER,
  output logic                TXSTART,
  output logic                CSEXTEND,
  output logic [31:0]         TXDATA,
  input  logic                SPIBUSY,
  input  logic                SPICOMPLETE,
  input  logic [31:0]         RXDATA
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_RESP,
    S_HOLD
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [31:0]       txdata_q, txdata_d;
  logic              last_q, last_d;
  logic              cse_q, cse_d;
  logic [27:0]       cfg_q, cfg_d;
  logic [31:0]       rsp_data_q, rsp_data_d;

  logic              win_found;
  logic [PW-1:0]     win_idx;
  logic [PW-1:0]     scan_idx;
  int                scan_int;

  logic [PW-1:0]     sel_idx;
  logic [31:0]       data_sel;
  logic [31:0]       cfg_sel;
  logic              last_sel;
  logic [3:0]        unused_cfg;

  logic [NREQ-1:0]   rdy;
  logic              txstart;
  logic [NREQ-1:0]   rsp_vld;

  // Round-robin winner: first valid requester starting just after ptr.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_int  = 0;
    scan_idx  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      scan_int = (int'(ptr_q) + k) % NREQ;
      scan_idx = PW'(scan_int);
      if (!win_found && REQ_VALID[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Lane mux: in IDLE the candidate is the winner, otherwise the current owner.
  assign sel_idx = (state_q == S_IDLE) ? win_idx : owner_q;

  always_comb begin
    data_sel = '0;
    cfg_sel  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (PW'(i) == sel_idx) begin
        data_sel = REQ_DATA[32*i +: 32];
        cfg_sel  = REQ_CFG[32*i +: 32];
      end
    end
  end

  assign last_sel   = REQ_LAST[sel_idx];
  assign unused_cfg = cfg_sel[31:28];

  // Next-state, handshake and datapath updates.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    gnt_d      = gnt_q;
    txdata_d   = txdata_q;
    last_d     = last_q;
    cse_d      = cse_q;
    cfg_d      = cfg_q;
    rsp_data_d = rsp_data_q;
    rdy        = '0;
    txstart    = 1'b0;
    rsp_vld    = '0;

    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          rdy[win_idx] = 1'b1;
          owner_d      = win_idx;
          gnt_d        = NREQ'(1) << win_idx;
          txdata_d     = data_sel;
          last_d       = last_sel;
          cse_d        = !last_sel;
          cfg_d        = cfg_sel[27:0];
          state_d      = S_START;
        end
      end

      S_START: begin
        if (!SPIBUSY) begin
          txstart = 1'b1;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        // SPICOMPLETE is only honoured here; stray pulses elsewhere are ignored.
        if (SPICOMPLETE) begin
          rsp_data_d = RXDATA;
          state_d    = S_RESP;
        end
      end

      S_RESP: begin
        rsp_vld = gnt_q;
        if (last_q) begin
          ptr_d   = owner_q;
          gnt_d   = '0;
          cse_d   = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_HOLD;
        end
      end

      S_HOLD: begin
        // Grant is kept until the owner's LAST word; an idle owner blocks all others.
        rdy = gnt_q;
        if (REQ_VALID[owner_q]) begin
          txdata_d = data_sel;
          last_d   = last_sel;
          cse_d    = !last_sel;
          state_d  = S_START;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge SYSCLK or negedge SYSRSTB) begin
    if (!SYSRSTB) begin
      state_q    <= S_IDLE;
      ptr_q      <= PW'(NREQ - 1);
      owner_q    <= '0;
      gnt_q      <= '0;
      txdata_q   <= '0;
      last_q     <= 1'b0;
      cse_q      <= 1'b0;
      cfg_q      <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      gnt_q      <= gnt_d;
      txdata_q   <= txdata_d;
      last_q     <= last_d;
      cse_q      <= cse_d;
      cfg_q      <= cfg_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // READY is combinational from REQ_VALID, so it is forced low while reset is held.
  assign REQ_READY = rdy & {NREQ{SYSRSTB}};
  assign RSP_VALID = rsp_vld;
  assign RSP_DATA  = rsp_data_q;
  assign GNT       = gnt_q;
  assign TXSTART   = txstart;
  assign CSEXTEND  = cse_q;
  assign TXDATA    = txdata_q;

  assign CLKDR   = cfg_q[7:0];
  assign CSSETUP = cfg_q[11:8];
  assign CSHOLD  = cfg_q[15:12];
  assign DWIDTH  = cfg_q[24:16];
  assign CPOL    = cfg_q[25];
  assign CPHA    = cfg_q[26];
  assign BORDER  = cfg_q[27];

endmodule

// File: tb/tb_sc_spi_arb.sv
// -----------------------------------------------------------------------------
// tb_sc_spi_arb : self-checking bench for sc_spi_arb (NREQ = 2).
// The bench plays the SPI engine and the requesters; expected owners come from
// a round-robin pointer model, expected data from the words the bench sent.
// -----------------------------------------------------------------------------
module tb_sc_spi_arb;

  localparam int NR = 2;

  logic              SYSCLK = 1'b0;
  logic              SYSRSTB = 1'b0;
  logic [NR-1:0]     REQ_VALID;
  logic [NR-1:0]     REQ_READY;
  logic [NR-1:0]     REQ_LAST;
  logic [NR*32-1:0]  REQ_DATA;
  logic [NR*32-1:0]  REQ_CFG;
  logic [NR-1:0]     RSP_VALID;
  logic [31:0]       RSP_DATA;
  logic [NR-1:0]     GNT;
  logic [7:0]        CLKDR;
  logic [3:0]        CSSETUP;
  logic [3:0]        CSHOLD;
  logic [8:0]        DWIDTH;
  logic              CPOL;
  logic              CPHA;
  logic              BORDER;
  logic              TXSTART;
  logic              CSEXTEND;
  logic [31:0]       TXDATA;
  logic              SPIBUSY;
  logic              SPICOMPLETE;
  logic [31:0]       RXDATA;

  logic [27:0]       cfg_out;
  logic [31:0]       txn_cfg;
  int                vectors = 0;
  int                miscompares = 0;
  int                mdl_ptr;

  always #5 SYSCLK = ~SYSCLK;

  assign cfg_out = {BORDER, CPHA, CPOL, DWIDTH, CSHOLD, CSSETUP, CLKDR};

  sc_spi_arb #(.NREQ(NR)) dut (
    .SYSCLK      (SYSCLK),
    .SYSRSTB     (SYSRSTB),
    .REQ_VALID   (REQ_VALID),
    .REQ_READY   (REQ_READY),
    .REQ_LAST    (REQ_LAST),
    .REQ_DATA    (REQ_DATA),
    .REQ_CFG     (REQ_CFG),
    .RSP_VALID   (RSP_VALID),
    .RSP_DATA    (RSP_DATA),
    .GNT         (GNT),
    .CLKDR       (CLKDR),
    .CSSETUP     (CSSETUP),
    .CSHOLD      (CSHOLD),
    .DWIDTH      (DWIDTH),
    .CPOL        (CPOL),
    .CPHA        (CPHA),
    .BORDER      (BORDER),
    .TXSTART     (TXSTART),
    .CSEXTEND    (CSEXTEND),
    .TXDATA      (TXDATA),
    .SPIBUSY     (SPIBUSY),
    .SPICOMPLETE (SPICOMPLETE),
    .RXDATA      (RXDATA)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Round-robin reference: first valid index after the pointer, wrapping.
  function automatic int rr_win(input logic [NR-1:0] v, input int p);
    for (int k = 1; k <= NR; k++) begin
      int i;
      i = (p + k) % NR;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic rand_lanes();
    for (int i = 0; i < NR; i++) begin
      REQ_DATA[32*i +: 32] = $urandom;
      REQ_CFG[32*i +: 32]  = $urandom;
    end
    REQ_LAST = NR'($urandom);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"},    32'(REQ_READY), 0);
    chk({tag, "_rspvld"},   32'(RSP_VALID), 0);
    chk({tag, "_rspdata"},  RSP_DATA, 0);
    chk({tag, "_gnt"},      32'(GNT), 0);
    chk({tag, "_txstart"},  32'(TXSTART), 0);
    chk({tag, "_csext"},    32'(CSEXTEND), 0);
    chk({tag, "_txdata"},   TXDATA, 0);
    chk({tag, "_cfg"},      32'(cfg_out), 0);
  endtask

  // One word from requester r, entered just after a clock edge while the DUT
  // is able to accept (IDLE with r as winner, or HOLD owned by r).
  task automatic xfer(input int r, input logic lst, input logic first, input int busy,
                      input logic [31:0] d, input logic [31:0] rx);
    logic [NR-1:0] oh;
    int gap;
    oh = NR'(1) << r;
    rand_lanes();
    REQ_DATA[32*r +: 32] = d;
    REQ_LAST[r] = lst;
    @(negedge SYSCLK);
    chk("ready", 32'(REQ_READY), 32'(oh));
    if (first) txn_cfg = REQ_CFG[32*r +: 32];
    @(posedge SYSCLK); #1;
    SPIBUSY = (busy > 0);
    rand_lanes();
    for (int i = 0; i < busy; i++) begin
      @(negedge SYSCLK);
      chk("txstart_busy", 32'(TXSTART), 0);
      chk("gnt_busy", 32'(GNT), 32'(oh));
      @(posedge SYSCLK); #1;
    end
    SPIBUSY = 1'b0;
    @(negedge SYSCLK);
    chk("txstart", 32'(TXSTART), 1);
    chk("gnt", 32'(GNT), 32'(oh));
    chk("txdata", TXDATA, d);
    chk("csextend", 32'(CSEXTEND), 32'(!lst));
    chk("cfg", 32'(cfg_out), {4'h0, txn_cfg[27:0]});
    chk("ready_start", 32'(REQ_READY), 0);
    @(posedge SYSCLK); #1;
    SPIBUSY = 1'b1;
    gap = $urandom_range(1, 3);
    repeat (gap) begin
      @(negedge SYSCLK);
      chk("txstart_wait", 32'(TXSTART), 0);
      chk("rsp_early", 32'(RSP_VALID), 0);
      @(posedge SYSCLK); #1;
    end
    SPICOMPLETE = 1'b1;
    RXDATA = rx;
    @(posedge SYSCLK); #1;
    SPICOMPLETE = 1'b0;
    SPIBUSY = 1'b0;
    RXDATA = $urandom;
    @(negedge SYSCLK);
    chk("rsp_valid", 32'(RSP_VALID), 32'(oh));
    chk("rsp_data", RSP_DATA, rx);
    @(posedge SYSCLK); #1;
    chk("rsp_pulse", 32'(RSP_VALID), 0);
    if (lst) begin
      chk("gnt_release", 32'(GNT), 0);
      chk("csext_release", 32'(CSEXTEND), 0);
      mdl_ptr = r;
    end else begin
      chk("gnt_hold", 32'(GNT), 32'(oh));
    end
  endtask

  // Owner r drops VALID for n cycles while in HOLD; nothing may move.
  task automatic stall(input int r, input int n);
    logic [NR-1:0] oh;
    oh = NR'(1) << r;
    REQ_VALID[r] = 1'b0;
    repeat (n) begin
      @(negedge SYSCLK);
      chk("stall_ready", 32'(REQ_READY), 32'(oh));
      chk("stall_txstart", 32'(TXSTART), 0);
      chk("stall_gnt", 32'(GNT), 32'(oh));
      @(posedge SYSCLK); #1;
    end
    REQ_VALID[r] = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r;
    int n;
    REQ_VALID   = '1;
    REQ_LAST    = '0;
    REQ_DATA    = '0;
    REQ_CFG     = '0;
    SPIBUSY     = 1'b0;
    SPICOMPLETE = 1'b0;
    RXDATA      = '0;
    rand_lanes();
    SYSRSTB     = 1'b0;
    repeat (3) @(posedge SYSCLK);
    #1;
    chk_all_zero("reset");
    REQ_VALID = '0;
    SYSRSTB   = 1'b1;
    mdl_ptr   = NR - 1;
    @(posedge SYSCLK); #1;
    chk_all_zero("idle");

    // Single word from requester 0.
    REQ_VALID = 2'b01;
    xfer(0, 1'b1, 1'b1, 0, 32'hA5A5_1234, 32'h0000_00C3);

    // Multi-word from requester 1 while requester 0 keeps asking.
    REQ_VALID = 2'b11;
    r = rr_win(REQ_VALID, mdl_ptr);
    xfer(r, 1'b0, 1'b1, 0, $urandom, $urandom);
    xfer(r, 1'b0, 1'b0, 1, $urandom, $urandom);
    xfer(r, 1'b1, 1'b0, 0, $urandom, $urandom);

    // Round-robin across four single-word transactions.
    for (int t = 0; t < 4; t++) begin
      r = rr_win(REQ_VALID, mdl_ptr);
      xfer(r, 1'b1, 1'b1, $urandom_range(0, 1), $urandom, $urandom);
    end

    // Busy engine for 5 cycles after acceptance.
    r = rr_win(REQ_VALID, mdl_ptr);
    xfer(r, 1'b1, 1'b1, 5, $urandom, $urandom);

    // Owner stalls mid-transaction for 10 cycles.
    r = rr_win(REQ_VALID, mdl_ptr);
    xfer(r, 1'b0, 1'b1, 0, $urandom, $urandom);
    stall(r, 10);
    xfer(r, 1'b1, 1'b0, 0, $urandom, $urandom);

    // Asynchronous reset while waiting on the engine.
    REQ_VALID = 2'b10;
    rand_lanes();
    @(posedge SYSCLK); #1;
    SPIBUSY = 1'b0;
    @(posedge SYSCLK); #1;
    SPIBUSY = 1'b1;
    @(negedge SYSCLK); #1;
    SYSRSTB = 1'b0;
    #1;
    chk_all_zero("rst_wait");
    REQ_VALID   = '0;
    SPICOMPLETE = 1'b1;
    RXDATA      = $urandom;
    @(posedge SYSCLK); #1;
    SPICOMPLETE = 1'b0;
    SPIBUSY     = 1'b0;
    SYSRSTB     = 1'b1;
    mdl_ptr     = NR - 1;
    @(posedge SYSCLK); #1;
    SPICOMPLETE = 1'b1;
    @(posedge SYSCLK); #1;
    SPICOMPLETE = 1'b0;
    repeat (3) begin
      @(negedge SYSCLK);
      chk("post_rst_rsp", 32'(RSP_VALID), 0);
      chk("post_rst_gnt", 32'(GNT), 0);
      chk("post_rst_txstart", 32'(TXSTART), 0);
      @(posedge SYSCLK); #1;
    end
    REQ_VALID = 2'b11;
    r = rr_win(REQ_VALID, mdl_ptr);
    xfer(r, 1'b1, 1'b1, 0, $urandom, $urandom);

    // Randomized transactions.
    for (int t = 0; t < 30; t++) begin
      REQ_VALID = NR'($urandom_range(1, (1 << NR) - 1));
      r = rr_win(REQ_VALID, mdl_ptr);
      n = $urandom_range(1, 3);
      for (int w = 0; w < n; w++) begin
        if (w > 0) begin
          REQ_VALID = NR'($urandom);
          REQ_VALID[r] = 1'b1;
          stall(r, $urandom_range(0, 2));
        end
        xfer(r, (w == n - 1), (w == 0), $urandom_range(0, 3), $urandom, $urandom);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
